// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern event logging slice.
//
// Contents:
//   PATT_W       width of the upstream serial pattern the detector matches
//   STAMP_W_DEF  default timestamp width
//   DEPTH_DEF    default log FIFO depth
//   stamp_t      default-width timestamp
//   log_entry_t  one logged event; currently only the stamp, with room to
//                add a pattern id once the detector reports one
package pattern_pkg;

  localparam int PATT_W      = 5;
  localparam int STAMP_W_DEF = 16;
  localparam int DEPTH_DEF   = 8;

  typedef logic [STAMP_W_DEF-1:0] stamp_t;

  typedef struct packed {
    stamp_t stamp;
  } log_entry_t;

endpackage

// File: rtl/pattern_event_logger_if.sv
// Read port of the event logger: a valid/ready stream of timestamps.
//
// Signals:
//   out_valid  head of the log holds a stamp
//   out_ready  consumer takes the head this cycle
//   out_stamp  stamp at the head of the log
//
// Modports:
//   master  the logger (drives valid/stamp, sees ready)
//   slave   the consumer (sees valid/stamp, drives ready)
interface pattern_event_logger_if #(
  parameter int STAMP_W = 16
) ();

  logic               out_valid;
  logic               out_ready;
  logic [STAMP_W-1:0] out_stamp;

  modport master (
    output out_valid,
    output out_stamp,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_stamp,
    output out_ready
  );

endinterface

// File: rtl/pattern_log_fifo.sv
// First-word fall-through FIFO holding logged timestamps.
//
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   clear         synchronous flush; wins over push/pop in the same cycle
//   push, din     write request and data
//   pop           read request; ignored while empty
//   dout          head entry, zero while empty
//   full, empty   occupancy flags
//   fill          occupancy, 0..DEPTH
//
// A push while full is accepted only when a pop happens in the same cycle,
// so the slot being vacated is reused. Storage itself is not reset; only
// pointers and occupancy are, which is enough because dout is masked
// while the FIFO is empty.
module pattern_log_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      fill_q;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (fill_q == '0);
  assign full    = (fill_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_q <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr];
  assign fill = fill_q;

endmodule

// File: rtl/pattern_event_logger.sv
// Timestamps match events from the serial pattern detector and buffers the
// stamps for a consumer to drain over a valid/ready read port.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   clear        synchronous flush of log, counters and flags
//   patt         match indication from the detector, sampled every cycle
//   rd           read port (out_valid / out_ready / out_stamp)
//   fill         current log occupancy
//   match_count  saturating count of all events, logged or dropped
//   overflow     sticky: an event was dropped because the log was full
//
// Build option:
//   MATCH_EDGE_EN  when defined, only a rising edge of patt is an event, so
//                  a held patt logs once; otherwise every cycle with patt
//                  high is an event.
module pattern_event_logger
  import pattern_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int STAMP_W = STAMP_W_DEF,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       patt,
  pattern_event_logger_if.master     rd,
  output logic [$clog2(DEPTH):0]     fill,
  output logic [CNT_W-1:0]           match_count,
  output logic                       overflow
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [STAMP_W-1:0] stamp_q;
  logic               evt;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic               drop;

  // Free-running stamp; its value in the event cycle is what gets logged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   stamp_q <= '0;
    else if (clear) stamp_q <= '0;
    else            stamp_q <= stamp_q + 1'b1;
  end

`ifdef MATCH_EDGE_EN
  logic patt_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   patt_prev <= 1'b0;
    else if (clear) patt_prev <= 1'b0;
    else            patt_prev <= patt;
  end

  assign evt = patt && !patt_prev && !clear;
`else
  assign evt = patt && !clear;
`endif

  // A full log still takes the event when the head leaves in the same cycle.
  assign pop  = rd.out_valid && rd.out_ready;
  assign push = evt;
  assign drop = evt && full && !pop;

  pattern_log_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (STAMP_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (push),
    .din     (stamp_q),
    .pop     (pop),
    .dout    (rd.out_stamp),
    .full    (full),
    .empty   (empty),
    .fill    (fill)
  );

  assign rd.out_valid = !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_count <= '0;
      overflow    <= 1'b0;
    end else if (clear) begin
      match_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (evt)  match_count <= sat_inc(match_count);
      if (drop) overflow    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pattern_event_logger.sv
module tb_pattern_event_logger;
  import pattern_pkg::*;

  localparam int DEPTH   = 8;
  localparam int STAMP_W = 16;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             clear = 1'b0;
  logic             patt = 1'b0;
  logic [3:0]       fill;
  logic [CNT_W-1:0] match_count;
  logic             overflow;

  pattern_event_logger_if #(.STAMP_W(STAMP_W)) rd ();

  pattern_event_logger #(
    .DEPTH   (DEPTH),
    .STAMP_W (STAMP_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .patt        (patt),
    .rd          (rd),
    .fill        (fill),
    .match_count (match_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [STAMP_W-1:0] exp_q[$];
  logic [STAMP_W-1:0] m_stamp;
  logic [3:0]         m_fill;
  logic [CNT_W-1:0]   m_count;
  logic               m_ovf;
`ifdef MATCH_EDGE_EN
  logic               m_prev;
`endif

  task automatic model_reset();
    m_stamp = '0;
    m_fill  = '0;
    m_count = '0;
    m_ovf   = 1'b0;
`ifdef MATCH_EDGE_EN
    m_prev  = 1'b0;
`endif
    exp_q.delete();
  endtask

  // Drive one cycle and advance the model. Callers that pop must remove the
  // head from exp_q themselves before calling (that is where they compare).
  task automatic step(input logic p, input logic r, input logic c);
    logic pop, full, evt;
    patt = p;
    rd.out_ready = r;
    clear = c;
    pop  = r && (m_fill != 0);
    full = (m_fill == 4'(DEPTH));
`ifdef MATCH_EDGE_EN
    evt = p && !m_prev;
`else
    evt = p;
`endif
    if (c) begin
      model_reset();
    end else begin
      if (evt) begin
        if (m_count != {CNT_W{1'b1}}) m_count = m_count + 1'b1;
        if (!full || pop) begin
          exp_q.push_back(m_stamp);
          m_fill = m_fill + 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (pop) m_fill = m_fill - 1'b1;
      m_stamp = m_stamp + 1'b1;
`ifdef MATCH_EDGE_EN
      m_prev = p;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    patt = 1'b0;
    clear = 1'b0;
    rd.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (rd.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b want=0", rd.out_valid); end
    n_vec++; if (rd.out_stamp !== 16'h0) begin n_err++; $display("FAIL reset_stamp got=%h want=0000", rd.out_stamp); end
    n_vec++; if (fill !== 4'd0) begin n_err++; $display("FAIL reset_fill got=%0d want=0", fill); end
    n_vec++; if (match_count !== 8'd0) begin n_err++; $display("FAIL reset_count got=%0d want=0", match_count); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%0b want=0", overflow); end
  endtask

  task automatic test_single();
    while (m_stamp != 16'd5) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    n_vec++; if (rd.out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got=%0b want=1", rd.out_valid); end
    n_vec++; if (rd.out_stamp !== 16'd5) begin n_err++; $display("FAIL single_stamp got=%0d want=5", rd.out_stamp); end
    n_vec++; if (fill !== 4'd1) begin n_err++; $display("FAIL single_fill got=%0d want=1", fill); end
    n_vec++; if (match_count !== 8'd1) begin n_err++; $display("FAIL single_count got=%0d want=1", match_count); end
    // Head must hold while not accepted.
    step(1'b0, 1'b0, 1'b0);
    n_vec++; if (rd.out_stamp !== 16'd5) begin n_err++; $display("FAIL single_hold got=%0d want=5", rd.out_stamp); end
    // Drain
    while (exp_q.size() > 0) begin
      n_vec++;
      if (rd.out_valid !== 1'b1 || rd.out_stamp !== exp_q[0]) begin
        n_err++; $display("FAIL single_drain got=%0b/%0d want=1/%0d", rd.out_valid, rd.out_stamp, exp_q[0]);
      end
      void'(exp_q.pop_front());
      step(1'b0, 1'b1, 1'b0);
    end
    n_vec++; if (rd.out_valid !== 1'b0) begin n_err++; $display("FAIL single_empty got=%0b want=0", rd.out_valid); end
    // Ready while empty changes nothing
    step(1'b0, 1'b1, 1'b0);
    n_vec++; if (fill !== 4'd0) begin n_err++; $display("FAIL ready_empty_fill got=%0d want=0", fill); end
  endtask

  task automatic test_held();
    int seen;
    step(1'b0, 1'b0, 1'b1);
    while (m_stamp != 16'd10) step(1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
`ifdef MATCH_EDGE_EN
    n_vec++; if (match_count !== 8'd1) begin n_err++; $display("FAIL held_count got=%0d want=1", match_count); end
    n_vec++; if (fill !== 4'd1) begin n_err++; $display("FAIL held_fill got=%0d want=1", fill); end
`else
    n_vec++; if (match_count !== 8'd3) begin n_err++; $display("FAIL held_count got=%0d want=3", match_count); end
    n_vec++; if (fill !== 4'd3) begin n_err++; $display("FAIL held_fill got=%0d want=3", fill); end
`endif
    seen = 0;
    while (exp_q.size() > 0) begin
      n_vec++;
      if (rd.out_valid !== 1'b1 || rd.out_stamp !== 16'(10 + seen)) begin
        n_err++; $display("FAIL held_drain got=%0b/%0d want=1/%0d", rd.out_valid, rd.out_stamp, 10 + seen);
      end
      void'(exp_q.pop_front());
      seen++;
      step(1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_overflow();
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    n_vec++; if (fill !== 4'd8) begin n_err++; $display("FAIL ovf_fill got=%0d want=8", fill); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got=%0b want=1", overflow); end
    n_vec++; if (match_count !== 8'd10) begin n_err++; $display("FAIL ovf_count got=%0d want=10", match_count); end
    // Full with push and pop together: head leaves, new stamp enters.
    n_vec++; if (rd.out_stamp !== exp_q[0]) begin n_err++; $display("FAIL full_pp_head got=%0d want=%0d", rd.out_stamp, exp_q[0]); end
    void'(exp_q.pop_front());
    step(1'b1, 1'b1, 1'b0);
    n_vec++; if (fill !== 4'd8) begin n_err++; $display("FAIL full_pp_fill got=%0d want=8", fill); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL full_pp_ovf got=%0b want=1", overflow); end
    n_vec++; if (match_count !== m_count) begin n_err++; $display("FAIL full_pp_count got=%0d want=%0d", match_count, m_count); end
    while (exp_q.size() > 0) begin
      n_vec++;
      if (rd.out_valid !== 1'b1 || rd.out_stamp !== exp_q[0]) begin
        n_err++; $display("FAIL ovf_drain got=%0b/%0d want=1/%0d", rd.out_valid, rd.out_stamp, exp_q[0]);
      end
      void'(exp_q.pop_front());
      step(1'b0, 1'b1, 1'b0);
    end
    n_vec++; if (fill !== 4'd0) begin n_err++; $display("FAIL ovf_drained got=%0d want=0", fill); end
  endtask

  task automatic test_clear();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    n_vec++; if (fill !== 4'd0) begin n_err++; $display("FAIL clr_fill got=%0d want=0", fill); end
    n_vec++; if (rd.out_valid !== 1'b0) begin n_err++; $display("FAIL clr_valid got=%0b want=0", rd.out_valid); end
    n_vec++; if (match_count !== 8'd0) begin n_err++; $display("FAIL clr_count got=%0d want=0", match_count); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL clr_ovf got=%0b want=0", overflow); end
    // Stamp counter restarts at zero right after clear.
    step(1'b1, 1'b0, 1'b0);
    n_vec++; if (rd.out_stamp !== 16'd0) begin n_err++; $display("FAIL clr_stamp got=%0d want=0", rd.out_stamp); end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b0, 1'b1);
    while (m_stamp != 16'hFFFF) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    n_vec++; if (fill !== 4'd2) begin n_err++; $display("FAIL wrap_fill got=%0d want=2", fill); end
    n_vec++; if (rd.out_stamp !== 16'hFFFF) begin n_err++; $display("FAIL wrap_first got=%h want=ffff", rd.out_stamp); end
    void'(exp_q.pop_front());
    step(1'b0, 1'b1, 1'b0);
    n_vec++; if (rd.out_stamp !== 16'h0001) begin n_err++; $display("FAIL wrap_second got=%h want=0001", rd.out_stamp); end
    void'(exp_q.pop_front());
    step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_saturate();
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    n_vec++; if (match_count !== 8'd255) begin n_err++; $display("FAIL sat_count got=%0d want=255", match_count); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL sat_ovf got=%0b want=1", overflow); end
    n_vec++; if (fill !== 4'd8) begin n_err++; $display("FAIL sat_fill got=%0d want=8", fill); end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++; if (fill !== 4'd0) begin n_err++; $display("FAIL rstmid_fill got=%0d want=0", fill); end
    n_vec++; if (rd.out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got=%0b want=0", rd.out_valid); end
    n_vec++; if (match_count !== 8'd0) begin n_err++; $display("FAIL rstmid_count got=%0d want=0", match_count); end
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    n_vec++; if (rd.out_stamp !== 16'd0) begin n_err++; $display("FAIL rstmid_stamp got=%0d want=0", rd.out_stamp); end
  endtask

  initial begin
    rd.out_ready = 1'b0;
    test_reset();
    test_single();
    test_held();
    test_overflow();
    test_clear();
    test_wrap();
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pattern_event_logger.md
Name: pattern_event_logger

Overview:
- Downstream consumer of the 5-bit serial pattern detector's `patt` output.
- Timestamps every match event against a free-running cycle counter and buffers the stamps in a small FIFO.
- Software or test logic drains the FIFO over a valid/ready read port.
- Also keeps a saturating match counter and a sticky overflow flag.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- STAMP_W, 16, width of the timestamp counter and of each stored stamp.
- CNT_W, 8, width of the saturating match counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush of FIFO, counters and flags.
- patt  in  1  match indication from the pattern detector, sampled each cycle.
- out_valid  out  1  FIFO head holds a valid stamp.
- out_ready  in  1  consumer accepts the head this cycle.
- out_stamp  out  STAMP_W  timestamp at the FIFO head.
- fill  out  $clog2(DEPTH)+1  current FIFO occupancy.
- match_count  out  CNT_W  total match events, saturating.
- overflow  out  1  sticky: at least one event dropped because the FIFO was full.

Behaviour:
- Reset (reset_n=0, async):
  - stamp counter, FIFO pointers, fill, match_count and overflow all clear to 0.
  - out_valid=0; out_stamp=0.
- Stamp counter:
  - increments by 1 every cycle, wrapping modulo 2^STAMP_W.
  - the value captured for an event is the counter value in the cycle patt=1.
- Match event: each cycle with patt=1 is one event, so a held patt gives one event per cycle.
- Push:
  - on an event, the stamp is written at the write pointer if the FIFO is not full, or if a pop occurs in the same cycle.
  - otherwise the event is dropped and overflow is set to 1.
  - overflow stays set until clear or reset.
- match_count:
  - increments on every event, accepted or dropped.
  - saturates at 2^CNT_W-1 and does not wrap.
- Read port:
  - registered first-word fall-through: out_valid = (fill != 0) and out_stamp = head entry.
  - pop occurs when out_valid && out_ready.
  - out_stamp must hold stable while out_valid=1 and out_ready=0.
- Latency: a push into an empty FIFO at cycle N gives out_valid=1 with that stamp at cycle N+1.
- Simultaneous push and pop:
  - fill unchanged.
  - when full, the push is accepted and no drop occurs.
  - when empty, no pop is possible because out_valid=0.
- Pointer behaviour:
  - pointers wrap modulo DEPTH.
  - fill ranges 0..DEPTH; full is fill==DEPTH.
- out_ready while empty: ignored, no state change.
- clear:
  - in the next cycle: fill=0, out_valid=0, match_count=0, overflow=0, stamp counter=0.
  - clear has priority over a push or pop in the same cycle; that cycle's event is discarded and not counted.
- Reset mid-operation: all state returns to reset values immediately; FIFO contents are not required to be cleared.

Optional Feature:
- Macro: MATCH_EDGE_EN.
- Defined: an event is a rising edge of patt only (patt=1 while the registered previous patt=0). A held patt produces one event. The previous-patt register resets to 0 and is cleared by clear.
- Undefined: every cycle with patt=1 is an event, as described above.

Decomposition:
- Shared package pattern_pkg:
  - default constants PATT_W=5, STAMP_W_DEF=16, DEPTH_DEF=8.
  - typedef stamp_t (logic [STAMP_W_DEF-1:0]).
  - typedef log_entry_t struct holding the stamp, for later extension with a pattern id.
- Sub-module pattern_log_fifo:
  - synchronous FWFT FIFO with push, pop, clear, full, empty and fill.
  - parameters DEPTH and width.
  - the top level holds the stamp counter, event qualification, match counter and overflow logic.

Test Plan:
- Reset, then pulse patt=1 at stamp 5 with out_ready=0 -> out_valid=1 next cycle, out_stamp=5, fill=1, match_count=1.
- patt high for 3 consecutive cycles at stamps 10..12, feature off -> three entries 10, 11, 12 drained in order, match_count=3. With MATCH_EDGE_EN -> one entry, 10.
- 10 events with DEPTH=8 and out_ready=0 -> fill=8, overflow=1, match_count=10; the first 8 stamps are retained in order.
- FIFO full and out_ready=1 with patt=1 in the same cycle -> head popped, new stamp accepted, fill stays 8, overflow unchanged.
- Assert clear together with patt=1 -> next cycle fill=0, out_valid=0, match_count=0, overflow=0, stamp counter=0.
- Pre-load the stamp counter near wrap: event at stamp 0xFFFF then at stamp 0x0001 -> stamps read 0xFFFF then 0x0001. Separately, 300 events with CNT_W=8 -> match_count=255.
